clint: RTL and testbench

CLINT -- requirements
Module: clint

---
 rtl/core_pkg.sv | 55 +++++
 rtl/clint_tick_gen.sv | 28 ++
 rtl/clint.sv | 104 ++++++++++
 tb/tb_clint.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared CLINT definitions: register offsets, address decode and byte-lane merge.
// Imported by clint and clint_tick_gen.
package core_pkg;

  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  localparam int unsigned PRESCALE_W = 16;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_TIME_LO,
    SEL_TIME_HI
  } reg_sel_e;

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  function automatic reg_sel_e decode_addr(input logic [15:0] addr);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (addr[1:0] == 2'b00) begin
      case (addr)
        MSIP_OFF:        sel = SEL_MSIP;
        MTIMECMP_LO_OFF: sel = SEL_CMP_LO;
        MTIMECMP_HI_OFF: sel = SEL_CMP_HI;
        MTIME_LO_OFF:    sel = SEL_TIME_LO;
        MTIME_HI_OFF:    sel = SEL_TIME_HI;
        default:         sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// Prescaler for mtime: tick is high in the cycle where the counter sits at PRESCALE-1.
// Combinational tick output, no backpressure; PRESCALE=1 ticks every cycle.
module clint_tick_gen
  import core_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + PRESCALE_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: msip, mtimecmp and mtime registers with timer/software interrupts.
// Always ready (gnt_o = req_i); response registered with exactly one cycle of latency.
module clint
  import core_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        timer_itr_o,
  output logic        soft_itr_o
);

  logic        tick;
  reg_sel_e    sel;
  logic        wr_en;

  logic [63:0] mtime_q,    mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q,     msip_d;
  logic        timer_q,    timer_d;
  rsp_t        rsp_q,      rsp_d;

  clint_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tick  (tick)
  );

  assign gnt_o = req_i;

  always_comb begin
    sel   = decode_addr(addr_i);
    wr_en = req_i & we_i & (sel != SEL_NONE);
  end

  // A bus write to either mtime half replaces the increment for that cycle.
  always_comb begin
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr_en) begin
      case (sel)
        SEL_MSIP:    if (be_i[0]) msip_d = wdata_i[0];
        SEL_CMP_LO:  mtimecmp_d[31:0]  = merge_be(mtimecmp_q[31:0],  wdata_i, be_i);
        SEL_CMP_HI:  mtimecmp_d[63:32] = merge_be(mtimecmp_q[63:32], wdata_i, be_i);
        SEL_TIME_LO: mtime_d = {mtime_q[63:32], merge_be(mtime_q[31:0], wdata_i, be_i)};
        SEL_TIME_HI: mtime_d = {merge_be(mtime_q[63:32], wdata_i, be_i), mtime_q[31:0]};
        default:     ;
      endcase
    end
    timer_d = (mtime_q >= mtimecmp_q);
  end

  always_comb begin
    rsp_d     = '0;
    rsp_d.vld = req_i;
    rsp_d.err = req_i & (sel == SEL_NONE);
    if (req_i && !we_i) begin
      case (sel)
        SEL_MSIP:    rsp_d.dat = {31'd0, msip_q};
        SEL_CMP_LO:  rsp_d.dat = mtimecmp_q[31:0];
        SEL_CMP_HI:  rsp_d.dat = mtimecmp_q[63:32];
        SEL_TIME_LO: rsp_d.dat = mtime_q[31:0];
        SEL_TIME_HI: rsp_d.dat = mtime_q[63:32];
        default:     rsp_d.dat = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      timer_q    <= 1'b0;
      rsp_q      <= '0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      timer_q    <= timer_d;
      rsp_q      <= rsp_d;
    end
  end

  assign rvalid_o    = rsp_q.vld;
  assign err_o       = rsp_q.err;
  assign rdata_o     = rsp_q.dat;
  assign timer_itr_o = timer_q;
  assign soft_itr_o  = msip_q;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: a vector table for the register map plus timed sequences.
// Two instances share the bus: PRESCALE=1 (dut) and PRESCALE=4 (dut4).
module tb_clint;

  logic        clk;
  logic        rst;
  logic        req, req4, we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic        gnt, rvalid, err, tmr, sft;
  logic [31:0] rdata;
  logic        gnt4, rvalid4, err4, tmr4, sft4;
  logic [31:0] rdata4;

  int unsigned cyc;
  int          tests;
  int          failed;

  clint #(.PRESCALE(1)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .err_o(err), .timer_itr_o(tmr), .soft_itr_o(sft)
  );

  clint #(.PRESCALE(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .req_i(req4), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt4), .rvalid_o(rvalid4),
    .rdata_o(rdata4), .err_o(err4), .timer_itr_o(tmr4), .soft_itr_o(sft4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; equals mtime of the PRESCALE=1 instance absent writes.
  always @(posedge clk) cyc <= rst ? 32'd0 : cyc + 32'd1;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_soft;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 64'(act), 64'(exp));
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, 64'(act), 64'(exp));
  endtask

  task automatic bus(input bit d4, input logic w, input logic [15:0] a,
                     input logic [31:0] wd, input logic [3:0] b,
                     output logic [31:0] rd, output logic e, output int unsigned ic);
    @(negedge clk);
    ic    = cyc;
    req   = !d4;
    req4  = d4;
    we    = w;
    addr  = a;
    wdata = wd;
    be    = b;
    #1;
    chk1("gnt", d4 ? gnt4 : gnt, 1'b1);
    @(posedge clk);
    #1;
    chk1("rvalid", d4 ? rvalid4 : rvalid, 1'b1);
    rd   = d4 ? rdata4 : rdata;
    e    = d4 ? err4 : err;
    req  = 1'b0;
    req4 = 1'b0;
    we   = 1'b0;
  endtask

  task automatic wr(input string name, input logic [15:0] a, input logic [31:0] wd,
                    input logic [3:0] b);
    logic [31:0] r;
    logic        e;
    int unsigned ic;
    bus(1'b0, 1'b1, a, wd, b, r, e, ic);
    chk1({name, "_err"}, e, 1'b0);
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic        e;
    int unsigned ic;
    bus(1'b0, 1'b0, a, 32'hFFFF_FFFF, 4'hF, r, e, ic);
    chk32(name, r, exp);
    chk1({name, "_err"}, e, 1'b0);
  endtask

  // Reset with a read held on the bus: it must be dropped and all outputs held at zero.
  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = 1'b1;
    req4 = 1'b1;
    we   = 1'b0;
    addr = 16'h0000;
    be   = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk1("rst_rvalid", rvalid, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk32("rst_rdata", rdata, 32'd0);
      chk1("rst_timer", tmr, 1'b0);
      chk1("rst_soft", sft, 1'b0);
      chk1("rst_rvalid4", rvalid4, 1'b0);
      chk1("rst_timer4", tmr4, 1'b0);
      chk1("rst_soft4", sft4, 1'b0);
    end
    @(negedge clk);
    rst  = 1'b0;
    req  = 1'b0;
    req4 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        e;
    int unsigned ic;
    bit          hit;

    tests = 0; failed = 0;
    rst = 1'b0; req = 1'b0; req4 = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; be = '0;

    vecs[0]  = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 16'h0000, 32'h0000_0000, 4'hF, 32'h0000_0001, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 16'h4000, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 16'h4000, 32'h0000_0000, 4'h0, 32'h1234_5678, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 16'h4000, 32'h0000_AB00, 4'h2, 32'h0000_0000, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 16'h4000, 32'h0000_0000, 4'hF, 32'h1234_AB78, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 16'h4004, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 16'h4004, 32'hDEAD_BEEF, 4'h8, 32'h0000_0000, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 16'h4004, 32'h0000_0000, 4'hF, 32'hDEFF_FFFF, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 16'h0008, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 16'h4002, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 16'h4002, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 16'h4000, 32'h0000_0000, 4'hF, 32'h1234_AB78, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 16'h0004, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 16'h0000, 32'h0000_0000, 4'hF, 32'h0000_0001, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 16'h0000, 32'h0000_0000, 4'h1, 32'h0000_0000, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 16'h0000, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 4'hE, 32'h0000_0000, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 16'h0000, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 16'hBFFC, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0, 1'b0};

    // Idle count after reset, then read mtime.
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    chk1("idle_timer", tmr, 1'b0);
    chk1("idle_soft", sft, 1'b0);
    rd_chk("idle_mtime_lo", 16'hBFF8, 32'd10);
    rd_chk("idle_mtime_hi", 16'hBFFC, 32'd0);
    @(posedge clk);
    #1;
    chk1("rvalid_idle_low", rvalid, 1'b0);

    // Software interrupt follows msip one cycle after each write.
    chk1("soft_before", sft, 1'b0);
    wr("msip_set", 16'h0000, 32'h0000_0001, 4'hF);
    chk1("soft_set", sft, 1'b1);
    rd_chk("msip_read", 16'h0000, 32'h0000_0001);
    wr("msip_clr", 16'h0000, 32'h0000_0000, 4'hF);
    chk1("soft_clr", sft, 1'b0);

    // Register-map vectors.
    do_reset();
    for (int i = 0; i < NV; i++) begin
      bus(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, r, e, ic);
      chk32($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
      chk1($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
      chk1($sformatf("vec%0d_soft", i), sft, vecs[i].exp_soft);
    end

    // Timer compare at mtimecmp = 20, then cleared by raising mtimecmp_hi.
    do_reset();
    wr("cmp_hi0", 16'h4004, 32'd0, 4'hF);
    wr("cmp_lo20", 16'h4000, 32'd20, 4'hF);
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (cyc == 32'd20) chk1("timer_at_20", tmr, 1'b0);
      if (cyc == 32'd21) begin
        chk1("timer_at_21", tmr, 1'b1);
        hit = 1'b1;
      end
    end
    chk1("timer_wait_done", hit, 1'b1);
    wr("cmp_hi1", 16'h4004, 32'd1, 4'hF);
    chk1("timer_hold_one_cycle", tmr, 1'b1);
    @(posedge clk);
    #1;
    chk1("timer_cleared", tmr, 1'b0);

    // 64-bit wrap; a write cycle must not also increment.
    wr("mtime_lo_wr", 16'hBFF8, 32'hFFFF_FFFE, 4'hF);
    rd_chk("mtime_lo_no_inc", 16'hBFF8, 32'hFFFF_FFFE);
    wr("mtime_hi_wr", 16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    rd_chk("mtime_lo_max", 16'hBFF8, 32'hFFFF_FFFF);
    rd_chk("mtime_hi_wrap", 16'hBFFC, 32'h0000_0000);
    rd_chk("mtime_lo_after_wrap", 16'hBFF8, 32'h0000_0001);

    // PRESCALE=4 instance: mtime = edges since reset / 4.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus(1'b1, 1'b0, 16'hBFF8, 32'd0, 4'hF, r, e, ic);
      chk32($sformatf("p4_mtime_%0d", ic), r, ic / 32'd4);
      chk1("p4_err", e, 1'b0);
    end

    // Reset in the middle of activity restores every register.
    wr("msip_pre", 16'h0000, 32'd1, 4'hF);
    wr("cmp_hi_pre", 16'h4004, 32'd0, 4'hF);
    wr("cmp_lo_pre", 16'h4000, 32'd0, 4'hF);
    @(posedge clk);
    #1;
    chk1("pre_rst_timer", tmr, 1'b1);
    chk1("pre_rst_soft", sft, 1'b1);
    do_reset();
    rd_chk("post_rst_msip", 16'h0000, 32'd0);
    rd_chk("post_rst_cmp_lo", 16'h4000, 32'hFFFF_FFFF);
    rd_chk("post_rst_cmp_hi", 16'h4004, 32'hFFFF_FFFF);
    bus(1'b0, 1'b0, 16'hBFF8, 32'd0, 4'hF, r, e, ic);
    chk32("post_rst_mtime", r, ic);
    bus(1'b1, 1'b0, 16'hBFF8, 32'd0, 4'hF, r, e, ic);
    chk32("post_rst_p4_mtime", r, ic / 32'd4);
    chk1("post_rst_timer", tmr, 1'b0);
    chk1("post_rst_soft", sft, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
